// File: rtl/morph_pkg.sv
// Shared types and default sizing for the morphology filter stages and
// their kernel LUT banks.
package morph_pkg;

  localparam int unsigned MORPH_KERNEL_WIDTH      = 71;
  localparam int unsigned MORPH_KERNEL_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FULL,
    DRAIN
  } kernel_load_state_t;

endpackage

// File: rtl/kernel_lut_ram.sv
// One kernel LUT bank: synchronous write, registered read.
// Out-of-range read addresses return zero.
module kernel_lut_ram #(
  parameter int unsigned DEPTH      = 71,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic signed [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0]        raddr,
  output logic signed [DATA_WIDTH-1:0] rdata
);

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (32'(raddr) < DEPTH) begin
      rdata <= mem[raddr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/kernel_lut_bank.sv
// Double-buffered kernel LUT responder: a shadow bank loads over AXI-Stream
// while the active bank serves reads; a swap promotes the shadow bank.
module kernel_lut_bank
  import morph_pkg::*;
#(
  parameter int unsigned KERNEL_WIDTH      = MORPH_KERNEL_WIDTH,
  parameter int unsigned KERNEL_DATA_WIDTH = MORPH_KERNEL_DATA_WIDTH
) (
  input  logic                                clk,
  input  logic                                areset_n,
  input  logic signed [KERNEL_DATA_WIDTH-1:0] axis_kernel_tdata,
  input  logic                                axis_kernel_tvalid,
  input  logic                                axis_kernel_tlast,
  output logic                                axis_kernel_tready,
  input  logic [$clog2(KERNEL_WIDTH)-1:0]     kernel_lut_address,
  output logic signed [KERNEL_DATA_WIDTH-1:0] kernel_lut_data,
  input  logic                                swap_req,
  output logic                                swap_done,
  output logic                                kernel_valid,
  output logic                                load_error
);

  localparam int unsigned   AW       = $clog2(KERNEL_WIDTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(KERNEL_WIDTH - 1);

  kernel_load_state_t state, state_nxt;
  logic [AW-1:0]      wr_idx, wr_idx_nxt;
  logic               active, active_nxt;
  logic               kernel_valid_nxt;
  logic               swap_done_nxt;
  logic               load_error_nxt;
  logic               beat;
  logic               wr_en;
  logic               rd_sel;
  logic               rd_mask;
  logic signed [KERNEL_DATA_WIDTH-1:0] rdata0, rdata1;

  assign axis_kernel_tready = areset_n && (state != FULL);
  assign beat               = axis_kernel_tvalid && axis_kernel_tready;

  always_comb begin
    state_nxt        = state;
    wr_idx_nxt       = wr_idx;
    active_nxt       = active;
    kernel_valid_nxt = kernel_valid;
    swap_done_nxt    = 1'b0;
    load_error_nxt   = 1'b0;
    wr_en            = 1'b0;
    case (state)
      // wr_idx stays 0 in IDLE, so IDLE and LOAD share the beat handling.
      IDLE, LOAD: begin
        if (beat) begin
          wr_en = 1'b1;
          if (wr_idx == LAST_IDX) begin
            wr_idx_nxt = '0;
            if (axis_kernel_tlast) begin
              state_nxt = FULL;
            end else begin
              load_error_nxt = 1'b1;
              state_nxt      = DRAIN;
            end
          end else if (axis_kernel_tlast) begin
            load_error_nxt = 1'b1;
            wr_idx_nxt     = '0;
            state_nxt      = IDLE;
          end else begin
            wr_idx_nxt = wr_idx + 1'b1;
            state_nxt  = LOAD;
          end
        end
      end
      FULL: begin
        if (swap_req) begin
          active_nxt       = ~active;
          kernel_valid_nxt = 1'b1;
          swap_done_nxt    = 1'b1;
          state_nxt        = IDLE;
        end
      end
      DRAIN: begin
        if (beat && axis_kernel_tlast) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state        <= IDLE;
      wr_idx       <= '0;
      active       <= 1'b0;
      kernel_valid <= 1'b0;
      swap_done    <= 1'b0;
      load_error   <= 1'b0;
      rd_sel       <= 1'b0;
      rd_mask      <= 1'b0;
    end else begin
      state        <= state_nxt;
      wr_idx       <= wr_idx_nxt;
      active       <= active_nxt;
      kernel_valid <= kernel_valid_nxt;
      swap_done    <= swap_done_nxt;
      load_error   <= load_error_nxt;
      // Bank select and mask follow the post-edge pointer so the read sampled
      // on the swap edge already comes from the newly promoted bank.
      rd_sel       <= active_nxt;
      rd_mask      <= kernel_valid_nxt;
    end
  end

  kernel_lut_ram #(
    .DEPTH      (KERNEL_WIDTH),
    .DATA_WIDTH (KERNEL_DATA_WIDTH)
  ) u_bank0 (
    .clk   (clk),
    .we    (wr_en && active),
    .waddr (wr_idx),
    .wdata (axis_kernel_tdata),
    .raddr (kernel_lut_address),
    .rdata (rdata0)
  );

  kernel_lut_ram #(
    .DEPTH      (KERNEL_WIDTH),
    .DATA_WIDTH (KERNEL_DATA_WIDTH)
  ) u_bank1 (
    .clk   (clk),
    .we    (wr_en && !active),
    .waddr (wr_idx),
    .wdata (axis_kernel_tdata),
    .raddr (kernel_lut_address),
    .rdata (rdata1)
  );

  assign kernel_lut_data = rd_mask ? (rd_sel ? rdata1 : rdata0) : '0;

endmodule
